// File: rtl/wb_stage_mlane.sv
// wb_stage_mlane: multi-lane writeback pipeline register with same-bundle RF collision masking
// and a debug commit trace. Define WB_TRACE_EN to serialise every lane through a trace queue.
module wb_stage_mlane #(
    parameter int LANES    = 2,
    parameter int DW       = 32,
    parameter int HILO_W   = 65,
    parameter int CP0_W    = 38,
    parameter int TQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES-1:0]    in_lane_valid,
    input  logic [LANES*32-1:0] in_pc,
    input  logic [LANES-1:0]    in_rf_we,
    input  logic [LANES*5-1:0]  in_rf_waddr,
    input  logic [LANES*DW-1:0] in_rf_wdata,
    input  logic [HILO_W-1:0]   in_hilo,
    input  logic [CP0_W-1:0]    in_cp0,
    output logic [LANES-1:0]    rf_we,
    output logic [LANES*5-1:0]  rf_waddr,
    output logic [LANES*DW-1:0] rf_wdata,
    output logic [HILO_W-1:0]   hilo_bus,
    output logic [CP0_W-1:0]    cp0_bus,
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_wen,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [31:0]         debug_wb_rf_wdata
);

    logic             acc;
    logic [LANES-1:0] eff_we;
    logic [LANES-1:0] kill;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding state (no latch).
    always_comb begin
        eff_we = '0;
        kill   = '0;
        for (int i = 0; i < LANES; i++) begin
            eff_we[i] = in_lane_valid[i] & in_rf_we[i] & (in_rf_waddr[i*5 +: 5] != 5'd0);
        end
        // A later lane writing the same register supersedes every earlier one.
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (eff_we[j] && (in_rf_waddr[j*5 +: 5] == in_rf_waddr[i*5 +: 5])) begin
                    kill[i] = 1'b1;
                end
            end
        end
    end

    assign acc = in_valid & in_ready & ~flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst || !acc) begin
            rf_we    <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            hilo_bus <= '0;
            cp0_bus  <= '0;
        end else begin
            rf_we    <= eff_we & ~kill;
            rf_waddr <= in_rf_waddr;
            rf_wdata <= in_rf_wdata;
            hilo_bus <= in_hilo;
            cp0_bus  <= in_cp0;
        end
    end

`ifdef WB_TRACE_EN
    localparam int PW = (TQ_DEPTH > 1) ? $clog2(TQ_DEPTH) : 1;
    localparam int CW = $clog2(TQ_DEPTH + 1);

    logic [31:0]   tq_pc    [2**PW];
    logic          tq_we    [2**PW];
    logic [4:0]    tq_waddr [2**PW];
    logic [31:0]   tq_wdata [2**PW];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] n_enq;
    logic [PW-1:0] slot [LANES];
    logic          deq;

    // Registers only: no path from in_valid to in_ready.
    assign in_ready = (count <= CW'(TQ_DEPTH - LANES));
    assign deq      = (count != '0);

    // Valid lanes are packed into consecutive slots in ascending lane order.
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = wr_ptr + PW'(n_enq);
            if (in_lane_valid[i]) begin
                n_enq = n_enq + CW'(1);
            end
        end
        if (!acc) begin
            n_enq = '0;
        end
    end

    // NOTE: queue storage is not reset; entries are only ever read while count says they are live.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (in_lane_valid[i]) begin
                    tq_pc[slot[i]]    <= in_pc[i*32 +: 32];
                    tq_we[slot[i]]    <= eff_we[i];
                    tq_waddr[slot[i]] <= in_rf_waddr[i*5 +: 5];
                    tq_wdata[slot[i]] <= 32'(in_rf_wdata[i*DW +: DW]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_enq);
            rd_ptr <= rd_ptr + PW'(deq);
            count  <= count + n_enq - CW'(deq);
        end
    end

    always_comb begin
        debug_wb_pc       = '0;
        debug_wb_rf_wen   = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        if (deq) begin
            debug_wb_pc       = tq_pc[rd_ptr];
            debug_wb_rf_wen   = {4{tq_we[rd_ptr]}};
            debug_wb_rf_wnum  = tq_waddr[rd_ptr];
            debug_wb_rf_wdata = tq_wdata[rd_ptr];
        end
    end

    count_in_range: assert property (@(posedge clk) disable iff (rst) count <= CW'(TQ_DEPTH));
`else
    logic          lv0_q;
    logic          twe0_q;
    logic [31:0]   pc0_q;
    logic [DW-1:0] wdata0;
    logic          unused_pc;

    assign in_ready  = 1'b1;
    // Only lane 0 is traced, so the upper lane PCs have no consumer here.
    assign unused_pc = ^in_pc;
    assign wdata0    = rf_wdata[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst || !acc) begin
            lv0_q  <= 1'b0;
            twe0_q <= 1'b0;
            pc0_q  <= '0;
        end else begin
            lv0_q  <= in_lane_valid[0];
            twe0_q <= eff_we[0];
            pc0_q  <= in_pc[31:0];
        end
    end

    assign debug_wb_pc       = lv0_q ? pc0_q : '0;
    assign debug_wb_rf_wen   = {4{lv0_q & twe0_q}};
    assign debug_wb_rf_wnum  = lv0_q ? rf_waddr[4:0] : '0;
    assign debug_wb_rf_wdata = lv0_q ? 32'(wdata0) : '0;
`endif

endmodule
